// File: rtl/status_sequencer.sv
// Operation status sequencer: IDLE -> BUSY -> DONE/ERROR -> IDLE.
// BUSY is bounded by TIMEOUT_CYCLES; a timeout lands in ERROR with a sticky flag.
module status_sequencer #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             done,
  input  logic             error,
  input  logic             ack,
  output logic [1:0]       Status,
  output logic             timeout,
  output logic [CNT_W-1:0] busy_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] ERROR = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             timeout_nxt;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = busy_cnt;
    timeout_nxt = timeout;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = BUSY;
          cnt_nxt   = '0;
        end
      end
      BUSY: begin
        // error beats done, and both beat the timeout in the final BUSY cycle
        if (error) begin
          state_nxt = ERROR;
        end else if (done) begin
          state_nxt = DONE;
        end else if (busy_cnt == LAST_CNT) begin
          state_nxt   = ERROR;
          timeout_nxt = 1'b1;
        end else begin
          cnt_nxt = busy_cnt + 1'b1;
        end
      end
      ERROR, DONE: begin
        if (ack) begin
          state_nxt   = IDLE;
          cnt_nxt     = '0;
          timeout_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt   = IDLE;
        cnt_nxt     = '0;
        timeout_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      busy_cnt <= cnt_nxt;
      timeout  <= timeout_nxt;
    end
  end

  assign Status = state;

endmodule

// File: tb/tb_status_sequencer.sv
// Directed scoreboard bench for status_sequencer: normal completion, timeout,
// collisions, ignored inputs and asynchronous mid-operation reset.
module tb_status_sequencer;

  localparam int TIMEOUT_CYCLES = 16;
  localparam int CNT_W          = 5;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             done;
  logic             error;
  logic             ack;
  logic [1:0]       Status;
  logic             timeout;
  logic [CNT_W-1:0] busy_cnt;

  typedef struct {
    string      tag;
    logic [7:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   compared;
  int   mismatched;

  status_sequencer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .done    (done),
    .error   (error),
    .ack     (ack),
    .Status  (Status),
    .timeout (timeout),
    .busy_cnt(busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_exp(input string tag, input logic [1:0] st, input logic to, input int cnt);
    exp_t e;
    e.tag = tag;
    e.v   = {st, to, 5'(cnt)};
    exp_q.push_back(e);
  endtask

  task automatic compare_out();
    exp_t       e;
    logic [7:0] obs;
    e   = exp_q.pop_front();
    obs = {Status, timeout, busy_cnt};
    compared++;
    assert (obs === e.v) else begin
      mismatched++;
      $error("FAIL %s: observed Status=%0d timeout=%0d busy_cnt=%0d expected Status=%0d timeout=%0d busy_cnt=%0d",
             e.tag, obs[7:6], obs[5], obs[4:0], e.v[7:6], e.v[5], e.v[4:0]);
    end
  endtask

  task automatic check_now(input string tag, input logic [1:0] st, input logic to, input int cnt);
    push_exp(tag, st, to, cnt);
    compare_out();
  endtask

  // drive inputs for one edge, record the expected result, sample 1 time unit after the edge
  task automatic step(input logic s, input logic d, input logic e, input logic a,
                      input string tag, input logic [1:0] st, input logic to, input int cnt);
    start = s;
    done  = d;
    error = e;
    ack   = a;
    push_exp(tag, st, to, cnt);
    @(posedge clk);
    #1;
    compare_out();
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n = 1'b0;
    start = 1'b0;
    done  = 1'b0;
    error = 1'b0;
    ack   = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_now("reset_state", 2'd0, 1'b0, 0);
    #2 rst_n = 1'b1;

    // normal completion with done in the 4th BUSY cycle
    step(1, 0, 0, 0, "norm_start", 2'd1, 1'b0, 0);
    step(0, 0, 0, 0, "norm_b1", 2'd1, 1'b0, 1);
    step(0, 0, 0, 0, "norm_b2", 2'd1, 1'b0, 2);
    step(0, 0, 0, 0, "norm_b3", 2'd1, 1'b0, 3);
    step(0, 1, 0, 0, "norm_done", 2'd3, 1'b0, 3);
    step(0, 0, 0, 1, "norm_ack", 2'd0, 1'b0, 0);
    step(0, 0, 0, 0, "idle_hold", 2'd0, 1'b0, 0);

    // timeout: 16 BUSY cycles then ERROR with the sticky flag
    step(1, 0, 0, 0, "to_start", 2'd1, 1'b0, 0);
    for (int i = 1; i < TIMEOUT_CYCLES; i++)
      step(0, 0, 0, 0, $sformatf("to_busy%0d", i), 2'd1, 1'b0, i);
    step(0, 0, 0, 0, "to_expire", 2'd2, 1'b1, 15);
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 0, $sformatf("to_hold%0d", i), 2'd2, 1'b1, 15);
    step(0, 0, 0, 1, "to_ack", 2'd0, 1'b0, 0);

    // error and done together: error wins, no timeout
    step(1, 0, 0, 0, "col_start", 2'd1, 1'b0, 0);
    step(0, 1, 1, 0, "col_err_done", 2'd2, 1'b0, 0);
    step(0, 0, 0, 1, "col_ack", 2'd0, 1'b0, 0);

    // done in the final BUSY cycle overrides the timeout
    step(1, 0, 0, 0, "last_done_start", 2'd1, 1'b0, 0);
    for (int i = 1; i < TIMEOUT_CYCLES; i++)
      step(0, 0, 0, 0, $sformatf("last_done_b%0d", i), 2'd1, 1'b0, i);
    step(0, 1, 0, 0, "last_done", 2'd3, 1'b0, 15);
    step(0, 0, 0, 1, "last_done_ack", 2'd0, 1'b0, 0);

    // error in the final BUSY cycle: ERROR without timeout
    step(1, 0, 0, 0, "last_err_start", 2'd1, 1'b0, 0);
    for (int i = 1; i < TIMEOUT_CYCLES; i++)
      step(0, 0, 0, 0, $sformatf("last_err_b%0d", i), 2'd1, 1'b0, i);
    step(0, 0, 1, 0, "last_err", 2'd2, 1'b0, 15);
    step(0, 0, 0, 1, "last_err_ack", 2'd0, 1'b0, 0);

    // ignored inputs: start held, ack in BUSY, done/error in DONE
    step(1, 0, 0, 0, "ign_start", 2'd1, 1'b0, 0);
    step(1, 0, 0, 1, "ign_ack_busy", 2'd1, 1'b0, 1);
    step(1, 0, 0, 0, "ign_start_busy", 2'd1, 1'b0, 2);
    step(1, 1, 0, 0, "ign_done", 2'd3, 1'b0, 2);
    for (int i = 0; i < 50; i++)
      step(1, i[0], i[1], 0, $sformatf("ign_done_hold%0d", i), 2'd3, 1'b0, 2);
    step(1, 0, 0, 1, "ign_ack_done", 2'd0, 1'b0, 0);
    step(0, 1, 1, 1, "ign_idle_inputs", 2'd0, 1'b0, 0);

    // start and ack together in IDLE still starts
    step(1, 0, 0, 1, "start_with_ack", 2'd1, 1'b0, 0);
    for (int i = 1; i <= 7; i++)
      step(0, 0, 0, 0, $sformatf("rst_b%0d", i), 2'd1, 1'b0, i);

    // asynchronous reset between edges with busy_cnt=7
    #2 rst_n = 1'b0;
    #1;
    check_now("async_rst", 2'd0, 1'b0, 0);
    step(1, 1, 1, 1, "rst_hold1", 2'd0, 1'b0, 0);
    step(1, 0, 0, 0, "rst_hold2", 2'd0, 1'b0, 0);
    #2 rst_n = 1'b1;
    step(1, 0, 0, 0, "first_start_after_rst", 2'd1, 1'b0, 0);
    step(0, 0, 0, 0, "post_rst_b1", 2'd1, 1'b0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/status_sequencer.md
STATUS_SEQUENCER -- requirements
Module: status_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: maximum number of clock cycles spent in BUSY; legal range is 2 or more.
REQ-002 SHALL have parameter CNT_W, default 5: width of the busy counter; 2**CNT_W SHALL be >= TIMEOUT_CYCLES.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: request to begin an operation; sampled only in IDLE.
REQ-006 SHALL have port done, input, 1 bit: the operation completed; sampled only in BUSY.
REQ-007 SHALL have port error, input, 1 bit: the operation failed; sampled only in BUSY.
REQ-008 SHALL have port ack, input, 1 bit: the consumer acknowledges a terminal state; sampled only in DONE or ERROR.
REQ-009 SHALL have port Status, output, 2 bits: registered state code, fed directly to the downstream Status-to-Flag decoder.
REQ-010 SHALL have port timeout, output, 1 bit: sticky flag, set when ERROR was entered because of a timeout.
REQ-011 SHALL have port busy_cnt, output, CNT_W bits: number of completed BUSY cycles in the current operation.

Function
REQ-012 SHALL encode states as IDLE=0, BUSY=1, ERROR=2, DONE=3, and Status SHALL equal the state register with no combinational path from any input.
REQ-013 SHALL, in IDLE, move to BUSY on the edge where start=1 and load busy_cnt=0; otherwise it SHALL stay in IDLE.
REQ-014 SHALL, in BUSY, apply this priority on each edge: error=1 -> ERROR; else done=1 -> DONE; else if busy_cnt==TIMEOUT_CYCLES-1 -> ERROR with timeout set to 1; else busy_cnt increments by 1.
REQ-015 SHALL therefore spend at most TIMEOUT_CYCLES cycles in BUSY; done or error asserted in the final BUSY cycle SHALL override the timeout.
REQ-016 SHALL hold busy_cnt unchanged on leaving BUSY, so the elapsed count stays visible in DONE and ERROR; busy_cnt SHALL never wrap.
REQ-017 SHALL, in DONE or ERROR, return to IDLE on the edge where ack=1, clearing timeout and busy_cnt; without ack it SHALL hold its state indefinitely.
REQ-018 SHALL ignore start outside IDLE, done and error outside BUSY, and ack outside DONE and ERROR.
REQ-019 SHALL take the IDLE-to-BUSY transition when start=1 and ack=1 occur together in IDLE (ack is a don't-care there).
REQ-020 SHALL always produce a defined next state for all four codes, with no held or latched values from incomplete decoding.

Reset
REQ-021 SHALL, on rst_n=0, immediately and without waiting for clk, force Status=0 (IDLE), timeout=0 and busy_cnt=0.
REQ-022 SHALL hold those values while rst_n=0, and SHALL abort any in-flight operation, including one mid-BUSY, with no trace left behind.
REQ-023 SHALL honour the first start sampled on the first rising edge after rst_n is released.

Verification
REQ-024 SHALL cover normal completion: start pulse, then done on the 4th BUSY cycle -> Status goes 1 then 3 with busy_cnt=3; then ack -> Status=0 and busy_cnt=0.
REQ-025 SHALL cover timeout: start and never assert done or error, TIMEOUT_CYCLES=16 -> Status=1 for exactly 16 cycles, then Status=2, timeout=1, busy_cnt=15; then ack -> Status=0 and timeout=0.
REQ-026 SHALL cover collisions: error=1 and done=1 in the same BUSY cycle -> Status=2 with timeout=0; done=1 in the 16th BUSY cycle -> Status=3 with timeout=0.
REQ-027 SHALL cover ignored inputs: start held high through BUSY and DONE, and ack pulsed while in BUSY -> no effect on state; without ack, DONE holds for 50 cycles.
REQ-028 SHALL cover mid-operation reset: rst_n=0 asserted between clock edges with busy_cnt=7 -> Status=0 and busy_cnt=0 before the next edge; start on the first edge after release -> Status=1.
